// File: rtl/an_fault_pkg.sv
// ---------------------------------------------------------------------------
// an_fault_pkg
// Shared definitions for the AN-code fault injector:
//   - fault_mode_e : injection mode encodings (matches the 2-bit mode port)
//   - LFSR_TAPS    : Galois feedback mask for x^32 + x^22 + x^2 + x + 1
//   - an_residue_ok: true when a codeword is a multiple of the AN multiplier
// ---------------------------------------------------------------------------
package an_fault_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_FLIP   = 2'd1,
    MODE_BURST  = 2'd2,
    MODE_STUCK1 = 2'd3
  } fault_mode_e;

  // Right-shifting Galois form: tap positions 32,22,2,1 map to bits 31,21,1,0.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic an_residue_ok(input logic [63:0] word,
                                         input logic [31:0] a);
    return (word % {32'd0, a}) == 64'd0;
  endfunction

endpackage

// File: rtl/an_fault_injector_multi_residue.sv
// ---------------------------------------------------------------------------
// an_residue_check
// Combinational AN-code check of one codeword.
//   word : CW_WIDTH-bit codeword under test
//   err  : 1 when word mod A_MULT != 0
// ---------------------------------------------------------------------------
module an_residue_check
  import an_fault_pkg::*;
#(
  parameter int CW_WIDTH = 29,
  parameter int A_MULT   = 1997
) (
  input  logic [CW_WIDTH-1:0] word,
  output logic                err
);

  always_comb begin
    err = ~an_residue_ok(64'(word), 32'(A_MULT));
  end

endmodule

// File: rtl/an_fault_injector_multi.sv
// ---------------------------------------------------------------------------
// an_fault_injector_multi
// Two-stage fault injector placed on an N_CH-wide AN-coded bus.
// Stage 1 optionally corrupts one channel (fixed or LFSR-chosen) when the
// LFSR value is below the threshold; stage 2 residue-checks every channel,
// registers the outputs and updates saturating coverage counters.
//   clk, rst (async, active-low)   clock / reset
//   clk_enable                     injection + LFSR enable
//   valid / ready                  input / output one-cycle strobes (latency 2)
//   layer_in / layer_out           N_CH codewords, channel c at [c*CW_WIDTH +: CW_WIDTH]
//   mode, ch_rand, ch_sel,
//   random_idx, constant_number    fault selection controls
//   inj_mask / det_mask            per-channel injected / residue-fail flags
//   inj_count, det_count,
//   miss_count                     saturating statistics
// ---------------------------------------------------------------------------
module an_fault_injector_multi
  import an_fault_pkg::*;
#(
  parameter int          CW_WIDTH  = 29,
  parameter int          N_CH      = 10,
  parameter int          A_MULT    = 1997,
  parameter int          BURST_LEN = 4,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2024,
  parameter int          CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk_enable,
  input  logic                       valid,
  input  logic [N_CH*CW_WIDTH-1:0]   layer_in,
  input  logic [1:0]                 mode,
  input  logic                       ch_rand,
  input  logic [$clog2(N_CH)-1:0]    ch_sel,
  input  logic [4:0]                 random_idx,
  input  logic [31:0]                constant_number,
  output logic [N_CH*CW_WIDTH-1:0]   layer_out,
  output logic                       ready,
  output logic [N_CH-1:0]            inj_mask,
  output logic [N_CH-1:0]            det_mask,
  output logic [CNT_W-1:0]           inj_count,
  output logic [CNT_W-1:0]           det_count,
  output logic [CNT_W-1:0]           miss_count
);

  localparam logic [31:0] SEED = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;

  logic [31:0]               lfsr;
  fault_mode_e               fmode;
  int unsigned               tgt;
  logic                      go;
  logic [CW_WIDTH-1:0]       fault_bits;
  logic [N_CH*CW_WIDTH-1:0]  s1_data_d;
  logic [N_CH-1:0]           s1_inj_d;

  logic                      s1_valid;
  logic [N_CH*CW_WIDTH-1:0]  s1_data;
  logic [N_CH-1:0]           s1_inj;
  logic [N_CH-1:0]           s1_det;

  logic                      any_inj;
  logic                      any_det;
  logic                      any_miss;

  // LFSR: advances whenever enabled, independent of valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= SEED;
    end else if (clk_enable) begin
      lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
    end
  end

  // Stage 1 fault construction. The target check also rejects out-of-range
  // ch_sel; an LFSR-derived channel is always in range.
  always_comb begin
    fmode = fault_mode_e'(mode);
    tgt   = ch_rand ? (32'(lfsr[31:16]) % 32'(N_CH)) : 32'(ch_sel);
    go    = clk_enable && (fmode != MODE_OFF) && (lfsr < constant_number) &&
            (32'(random_idx) < 32'(CW_WIDTH)) && (tgt < 32'(N_CH));

    fault_bits = '0;
    for (int unsigned j = 0; j < CW_WIDTH; j++) begin
      if (fmode == MODE_BURST) begin
        for (int unsigned k = 0; k < BURST_LEN; k++) begin
          if (j == (32'(random_idx) + k) % 32'(CW_WIDTH)) fault_bits[j] = 1'b1;
        end
      end else if (j == 32'(random_idx)) begin
        fault_bits[j] = 1'b1;
      end
    end

    s1_data_d = layer_in;
    s1_inj_d  = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (go && (tgt == c)) begin
        s1_inj_d[c] = 1'b1;
        if (fmode == MODE_STUCK1) begin
          s1_data_d[c*CW_WIDTH +: CW_WIDTH] = layer_in[c*CW_WIDTH +: CW_WIDTH] | fault_bits;
        end else begin
          s1_data_d[c*CW_WIDTH +: CW_WIDTH] = layer_in[c*CW_WIDTH +: CW_WIDTH] ^ fault_bits;
        end
      end
    end
  end

  // Stage 2 residue checks on the registered stage-1 words.
  for (genvar g = 0; g < N_CH; g++) begin : g_chk
    an_residue_check #(
      .CW_WIDTH (CW_WIDTH),
      .A_MULT   (A_MULT)
    ) u_chk (
      .word (s1_data[g*CW_WIDTH +: CW_WIDTH]),
      .err  (s1_det[g])
    );
  end

  always_comb begin
    any_inj  = |s1_inj;
    any_det  = |(s1_inj & s1_det);
    any_miss = |(s1_inj & ~s1_det);
  end

  // Counters are updated on the same edge that raises ready, so the values
  // seen alongside ready already include that transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s1_inj     <= '0;
      ready      <= 1'b0;
      layer_out  <= '0;
      inj_mask   <= '0;
      det_mask   <= '0;
      inj_count  <= '0;
      det_count  <= '0;
      miss_count <= '0;
    end else begin
      s1_valid <= valid;
      if (valid) begin
        s1_data <= s1_data_d;
        s1_inj  <= s1_inj_d;
      end
      ready <= s1_valid;
      if (s1_valid) begin
        layer_out <= s1_data;
        inj_mask  <= s1_inj;
        det_mask  <= s1_det;
        if (any_inj  && (inj_count  != '1)) inj_count  <= inj_count  + 1'b1;
        if (any_det  && (det_count  != '1)) det_count  <= det_count  + 1'b1;
        if (any_miss && (miss_count != '1)) miss_count <= miss_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_an_fault_injector_multi.sv
// ---------------------------------------------------------------------------
// tb_an_fault_injector_multi
// Self-checking bench: directed vector table, hand-written multi-cycle
// sequences (threshold gate, mid-flight reset, counter saturation) and a
// randomized phase, all checked against a transaction-level model.
// A second instance with 4-bit counters exercises saturation.
// ---------------------------------------------------------------------------
module tb_an_fault_injector_multi;

  localparam int          CW   = 29;
  localparam int          NCH  = 10;
  localparam int          A    = 1997;
  localparam int          BL   = 4;
  localparam int          W    = CW * NCH;
  localparam logic [31:0] SEED = 32'hACE1_2024;
  localparam logic [31:0] TMAX = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, clk_enable, valid, ch_rand;
  logic [W-1:0]  layer_in;
  logic [1:0]    mode;
  logic [3:0]    ch_sel;
  logic [4:0]    random_idx;
  logic [31:0]   constant_number;

  logic [W-1:0]   layer_out, layer_out_s;
  logic           ready, ready_s;
  logic [NCH-1:0] inj_mask, det_mask, inj_mask_s, det_mask_s;
  logic [15:0]    inj_count, det_count, miss_count;
  logic [3:0]     inj_count_s, det_count_s, miss_count_s;

  an_fault_injector_multi #(
    .CW_WIDTH (CW), .N_CH (NCH), .A_MULT (A), .BURST_LEN (BL),
    .LFSR_SEED (SEED), .CNT_W (16)
  ) dut (
    .clk (clk), .rst (rst), .clk_enable (clk_enable), .valid (valid),
    .layer_in (layer_in), .mode (mode), .ch_rand (ch_rand), .ch_sel (ch_sel),
    .random_idx (random_idx), .constant_number (constant_number),
    .layer_out (layer_out), .ready (ready), .inj_mask (inj_mask),
    .det_mask (det_mask), .inj_count (inj_count), .det_count (det_count),
    .miss_count (miss_count)
  );

  an_fault_injector_multi #(
    .CW_WIDTH (CW), .N_CH (NCH), .A_MULT (A), .BURST_LEN (BL),
    .LFSR_SEED (SEED), .CNT_W (4)
  ) dut_sat (
    .clk (clk), .rst (rst), .clk_enable (clk_enable), .valid (valid),
    .layer_in (layer_in), .mode (mode), .ch_rand (ch_rand), .ch_sel (ch_sel),
    .random_idx (random_idx), .constant_number (constant_number),
    .layer_out (layer_out_s), .ready (ready_s), .inj_mask (inj_mask_s),
    .det_mask (det_mask_s), .inj_count (inj_count_s), .det_count (det_count_s),
    .miss_count (miss_count_s)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic           v;
    logic [W-1:0]   data;
    logic [NCH-1:0] inj;
    logic [NCH-1:0] det;
  } txn_t;

  logic [31:0] m_lfsr;
  int unsigned m_inj, m_det, m_miss, s_inj, s_det, s_miss;
  txn_t        p1, due;
  int          n_cmp  = 0;
  int          n_fail = 0;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    int          taps [4] = '{32, 22, 2, 1};
    logic [31:0] poly;
    poly = '0;
    foreach (taps[i]) poly[taps[i]-1] = 1'b1;
    return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
  endfunction

  function automatic int unsigned sat_add(input int unsigned v, input logic hit,
                                          input int unsigned maxv);
    if (hit && v < maxv) return v + 1;
    return v;
  endfunction

  function automatic txn_t model_txn();
    txn_t        t;
    int unsigned ch;
    int unsigned idx;
    logic [63:0] w;
    logic        inject;
    t.v    = 1'b1;
    t.data = layer_in;
    t.inj  = '0;
    idx    = 32'(random_idx);
    ch     = ch_rand ? (32'(m_lfsr[31:16]) % NCH) : 32'(ch_sel);
    inject = clk_enable && (mode != 2'd0) && (m_lfsr < constant_number) &&
             (idx < CW) && (ch < NCH);
    if (inject) begin
      w = 64'(layer_in[ch*CW +: CW]);
      case (mode)
        2'd1: w = w ^ (64'd1 << idx);
        2'd2: for (int k = 0; k < BL; k++) w = w ^ (64'd1 << ((idx + k) % CW));
        default: w = w | (64'd1 << idx);
      endcase
      t.data[ch*CW +: CW] = w[CW-1:0];
      t.inj[ch] = 1'b1;
    end
    for (int c = 0; c < NCH; c++)
      t.det[c] = (64'(t.data[c*CW +: CW]) % 64'(A)) != 64'd0;
    return t;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // One clock: model samples inputs, DUT outputs compared #1 after the edge.
  task automatic tick();
    txn_t nt;
    nt.v = 1'b0; nt.data = '0; nt.inj = '0; nt.det = '0;
    if (valid) nt = model_txn();
    @(posedge clk);
    if (clk_enable) m_lfsr = lfsr_next(m_lfsr);
    due = p1;
    p1  = nt;
    if (due.v) begin
      m_inj  = sat_add(m_inj,  |due.inj, 65535);
      m_det  = sat_add(m_det,  |(due.inj & due.det), 65535);
      m_miss = sat_add(m_miss, |(due.inj & ~due.det), 65535);
      s_inj  = sat_add(s_inj,  |due.inj, 15);
      s_det  = sat_add(s_det,  |(due.inj & due.det), 15);
      s_miss = sat_add(s_miss, |(due.inj & ~due.det), 15);
    end
    #1;
    chk("ready", W'(ready), W'(due.v));
    chk("ready_sat", W'(ready_s), W'(due.v));
    if (due.v) begin
      chk("layer_out", layer_out, due.data);
      chk("inj_mask", W'(inj_mask), W'(due.inj));
      chk("det_mask", W'(det_mask), W'(due.det));
      chk("inj_count", W'(inj_count), W'(m_inj));
      chk("det_count", W'(det_count), W'(m_det));
      chk("miss_count", W'(miss_count), W'(m_miss));
      chk("inj_count_sat", W'(inj_count_s), W'(s_inj));
      chk("det_count_sat", W'(det_count_s), W'(s_det));
      chk("miss_count_sat", W'(miss_count_s), W'(s_miss));
    end
  endtask

  task automatic model_reset();
    m_lfsr = SEED;
    m_inj = 0; m_det = 0; m_miss = 0;
    s_inj = 0; s_det = 0; s_miss = 0;
    p1.v = 1'b0; p1.data = '0; p1.inj = '0; p1.det = '0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, W'(ready), '0);
    chk({tag, "_layer_out"}, layer_out, '0);
    chk({tag, "_masks"}, W'({inj_mask, det_mask}), '0);
    chk({tag, "_counts"}, W'({inj_count, det_count, miss_count}), '0);
    chk({tag, "_counts_sat"}, W'({inj_count_s, det_count_s, miss_count_s}), '0);
  endtask

  function automatic logic [W-1:0] base_bus();
    logic [W-1:0] b;
    for (int c = 0; c < NCH; c++) b[c*CW +: CW] = CW'(A * (c + 1));
    return b;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]     mode;
    logic [3:0]     ch;
    logic [4:0]     idx;
    logic [31:0]    thr;
    logic           en;
    logic [NCH-1:0] exp_inj;
    logic [NCH-1:0] exp_det;
    logic [CW-1:0]  exp_diff;
  } vec_t;

  vec_t vecs [11];
  int unsigned inj_before;
  int          tgt_ch;

  initial begin
    //          mode  ch     idx    thr   en    inj       det       diff on target
    vecs[0]  = '{2'd0, 4'd0,  5'd0,  TMAX, 1'b1, 10'h000, 10'h000, 29'h0};
    vecs[1]  = '{2'd1, 4'd3,  5'd0,  TMAX, 1'b1, 10'h008, 10'h008, 29'h1};
    vecs[2]  = '{2'd2, 4'd5,  5'd27, TMAX, 1'b1, 10'h020, 10'h020, 29'h1800_0003};
    vecs[3]  = '{2'd1, 4'd3,  5'd29, TMAX, 1'b1, 10'h000, 10'h000, 29'h0};
    vecs[4]  = '{2'd3, 4'd2,  5'd0,  TMAX, 1'b1, 10'h004, 10'h000, 29'h0};
    vecs[5]  = '{2'd3, 4'd0,  5'd1,  TMAX, 1'b1, 10'h001, 10'h001, 29'h2};
    vecs[6]  = '{2'd1, 4'd12, 5'd4,  TMAX, 1'b1, 10'h000, 10'h000, 29'h0};
    vecs[7]  = '{2'd1, 4'd1,  5'd4,  32'd0, 1'b1, 10'h000, 10'h000, 29'h0};
    vecs[8]  = '{2'd1, 4'd1,  5'd4,  TMAX, 1'b0, 10'h000, 10'h000, 29'h0};
    vecs[9]  = '{2'd2, 4'd9,  5'd31, TMAX, 1'b1, 10'h000, 10'h000, 29'h0};
    vecs[10] = '{2'd2, 4'd7,  5'd10, TMAX, 1'b1, 10'h080, 10'h080, 29'h3C00};

    rst = 1'b0; clk_enable = 1'b0; valid = 1'b0; ch_rand = 1'b0;
    layer_in = '0; mode = 2'd0; ch_sel = '0; random_idx = '0; constant_number = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst = 1'b1;

    // Table: each vector is one isolated transaction.
    for (int i = 0; i < 11; i++) begin
      layer_in = base_bus();
      mode = vecs[i].mode; ch_sel = vecs[i].ch; random_idx = vecs[i].idx;
      constant_number = vecs[i].thr; clk_enable = vecs[i].en; ch_rand = 1'b0;
      valid = 1'b1;
      tick();
      valid = 1'b0;
      tick();
      tgt_ch = (vecs[i].ch < 4'(NCH)) ? int'(vecs[i].ch) : 0;
      chk($sformatf("vec%0d_out", i), layer_out,
          base_bus() ^ (W'(vecs[i].exp_diff) << (tgt_ch * CW)));
      chk($sformatf("vec%0d_inj", i), W'(inj_mask), W'(vecs[i].exp_inj));
      chk($sformatf("vec%0d_det", i), W'(det_mask), W'(vecs[i].exp_det));
      if (i == 1) begin
        chk("flip_inj_count", W'(inj_count), W'(16'd1));
        chk("flip_det_count", W'(det_count), W'(16'd1));
      end
      if (i == 4) chk("stuck_miss_count", W'(miss_count), W'(16'd1));
    end

    // Threshold gate: 100 back-to-back pulses closed, then 100 open.
    clk_enable = 1'b1; mode = 2'd1; ch_rand = 1'b1;
    inj_before = m_inj;
    constant_number = 32'd0;
    for (int i = 0; i < 100; i++) begin
      valid = 1'b1; random_idx = 5'($urandom_range(0, CW - 1)); tick();
    end
    valid = 1'b0; tick(); tick();
    chk("gate_closed", W'(inj_count), W'(inj_before));
    constant_number = TMAX;
    for (int i = 0; i < 100; i++) begin
      valid = 1'b1; random_idx = 5'($urandom_range(0, CW - 1)); tick();
    end
    valid = 1'b0; tick(); tick();
    chk("gate_open", W'(inj_count), W'(inj_before + 100));

    // Reset between valid and ready: transaction dropped, state cleared.
    valid = 1'b1; tick();
    valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk_reset_state("midreset");
    @(negedge clk);
    rst = 1'b1; clk_enable = 1'b0;
    repeat (3) tick();
    // LFSR restarted at the seed: 0xACE1 mod 10 = 7.
    clk_enable = 1'b1; ch_rand = 1'b1; mode = 2'd1; random_idx = 5'd5;
    constant_number = TMAX; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    chk("seed_channel", W'(inj_mask), W'(10'h080));

    // Saturation: 20 more injections.
    for (int i = 0; i < 20; i++) begin
      valid = 1'b1; random_idx = 5'($urandom_range(0, CW - 1)); tick();
    end
    valid = 1'b0; tick(); tick();
    chk("sat_hold", W'(inj_count_s), W'(4'd15));
    chk("nosat_count", W'(inj_count), W'(16'd21));

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      valid      = ($urandom_range(0, 3) != 0);
      clk_enable = ($urandom_range(0, 4) != 0);
      mode       = 2'($urandom_range(0, 3));
      ch_rand    = 1'($urandom_range(0, 1));
      ch_sel     = 4'($urandom_range(0, 15));
      random_idx = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 2))
        0: constant_number = 32'd0;
        1: constant_number = TMAX;
        default: constant_number = $urandom;
      endcase
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 7) == 0) layer_in[c*CW +: CW] = CW'($urandom);
        else layer_in[c*CW +: CW] = CW'(A * $urandom_range(0, 268000));
      end
      tick();
    end
    valid = 1'b0; tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/an_fault_injector_multi.md
Name: an_fault_injector_multi

Overview:
- Parametrised successor to the single-line 29-bit error inserter in the TCB AN-coded top.
- Sits between a layer output bus (N_CH AN-coded codewords) and its consumer, e.g. layer2 -> comparator.
- Injects faults per transaction into one selected or pseudo-random channel, in one of three fault modes, gated by a probability threshold.
- Residue-checks every outgoing codeword against A_MULT and counts injected, detected and undetected faults for coverage statistics.

Parameters:
- CW_WIDTH, 29, bits per AN codeword.
- N_CH, 10, number of codewords on the bus.
- A_MULT, 1997, AN-code multiplier; a valid codeword satisfies word mod A_MULT == 0.
- BURST_LEN, 4, adjacent bits flipped in burst mode (1..CW_WIDTH).
- LFSR_SEED, 32'hACE1_2024, LFSR reset value; a value of 0 is replaced by 1.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-low reset.
- clk_enable, in, 1, injection/LFSR enable.
- valid, in, 1, one-cycle pulse: layer_in is valid.
- layer_in, in, N_CH*CW_WIDTH, codewords; channel c is bits [c*CW_WIDTH +: CW_WIDTH].
- mode, in, 2, 0 off, 1 single flip, 2 burst flip, 3 stuck-at-1.
- ch_rand, in, 1, 1: channel taken from LFSR; 0: taken from ch_sel.
- ch_sel, in, $clog2(N_CH), fixed target channel.
- random_idx, in, 5, target bit index (burst start bit in burst mode).
- constant_number, in, 32, injection threshold; inject when lfsr < constant_number.
- layer_out, out, N_CH*CW_WIDTH, possibly corrupted codewords.
- ready, out, 1, one-cycle pulse: layer_out and flags are valid.
- inj_mask, out, N_CH, channel corrupted in this transaction.
- det_mask, out, N_CH, channel fails the residue check.
- inj_count, out, CNT_W, faults injected (saturating).
- det_count, out, CNT_W, injected faults caught by the residue check (saturating).
- miss_count, out, CNT_W, injected faults not caught (saturating).

Behaviour:
- Reset (rst=0, async): layer_out=0, ready=0, inj_mask=0, det_mask=0, all counters=0, lfsr=LFSR_SEED, pipeline valid bits=0.
- LFSR: 32-bit Galois, taps 32,22,2,1. It advances every cycle clk_enable=1 and holds otherwise. Each transaction samples the pre-advance value.
- Stage 1, on the cycle valid=1:
  - go = clk_enable and mode!=0 and (lfsr < constant_number) and (random_idx < CW_WIDTH).
  - Target channel: ch_rand ? (lfsr[31:16] mod N_CH) : ch_sel. A ch_sel >= N_CH forces go=0.
  - Mode 1: flip bit random_idx.
  - Mode 2: flip bits random_idx .. random_idx+BURST_LEN-1, wrapping modulo CW_WIDTH within the same codeword.
  - Mode 3: force bit random_idx to 1. If the bit is already 1 the word is unchanged; inj_mask is still set and the fault is still counted.
  - The result is registered into stage 1 with its one-hot inj vector.
- Stage 2, one cycle later: each channel is tested word mod A_MULT != 0 -> det bit. Outputs are registered; ready pulses.
- Latency: ready is asserted exactly 2 cycles after valid.
- Throughput: back-to-back valid pulses are accepted every cycle. There is no backpressure; ready is not an input.
- Counters update on the ready cycle:
  - inj_count += |inj_mask.
  - det_count += |(inj_mask & det_mask).
  - miss_count += |(inj_mask & ~det_mask).
  - All counters saturate at 2^CNT_W-1.
- det_mask bits on non-injected channels flag upstream corruption. They are reported but not counted.
- clk_enable=0 mid-stream: data still passes through with latency 2; only injection and the LFSR freeze.
- Reset asserted mid-operation: in-flight transactions are dropped and no ready pulse follows.
- Mode or threshold changes take effect at the next valid.

Decomposition:
- Shared package an_fault_pkg:
  - mode encodings MODE_OFF, MODE_FLIP, MODE_BURST, MODE_STUCK1;
  - LFSR tap constant;
  - residue-check function an_residue_ok(word, A).
- One sub-module, an_residue_check: a combinational mod-A_MULT test on one CW_WIDTH word, instantiated N_CH times in stage 2.

Test Plan:
- Pass-through: mode=0, all channels = 1997*k (k=1..10), valid pulse. Required: ready exactly 2 cycles later, layer_out == layer_in, inj_mask=0, det_mask=0, all counters 0.
- Single flip: mode=1, ch_rand=0, ch_sel=3, random_idx=0, constant_number=32'hFFFF_FFFF. Required: channel 3 = 7988^1, inj_mask=10'b0000001000, det_mask equal to inj_mask, inj_count=1, det_count=1.
- Burst wrap: mode=2, random_idx=27, BURST_LEN=4. Required: bits 27, 28, 0, 1 of the target channel flipped; no other bits change; no other channel changes.
- Threshold gate: constant_number=0 with 100 valid pulses. Required: zero injections and inj_count=0. Then constant_number=32'hFFFF_FFFF with 100 pulses. Required: inj_count=100.
- Boundary index: random_idx=29, mode=1. Required: no injection. Then mode=3 on a bit already set. Required: data unchanged, inj_mask set, inj_count+1, miss_count+1.
- Saturation and reset: with CNT_W=4, run 20 injections. Required: inj_count holds at 15. Then pulse rst low between valid and ready. Required: counters and outputs 0, no ready pulse, LFSR back to seed.
